// File: rtl/alu32_pkg.sv
// Shared function codes and helpers for the registered 32-bit ALU.
// Optional ALU32_OVERFLOW_EN adds the signed overflow output.
package alu32_pkg;

  typedef logic [5:0] alu_fn_t;

  localparam alu_fn_t FN_ADD  = 6'b100000;
  localparam alu_fn_t FN_ADDU = 6'b100001;
  localparam alu_fn_t FN_SUB  = 6'b100010;
  localparam alu_fn_t FN_SUBU = 6'b100011;
  localparam alu_fn_t FN_AND  = 6'b100100;
  localparam alu_fn_t FN_OR   = 6'b100101;
  localparam alu_fn_t FN_XOR  = 6'b100110;
  localparam alu_fn_t FN_NOR  = 6'b100111;
  localparam alu_fn_t FN_SLT  = 6'b101010;
  localparam alu_fn_t FN_SLTU = 6'b101011;
  localparam alu_fn_t FN_SLLV = 6'b000100;
  localparam alu_fn_t FN_SRLV = 6'b000110;
  localparam alu_fn_t FN_SRAV = 6'b000111;

  localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu32_core.sv
// Combinational ALU datapath: decode, compute, flag illegal/overflow.
// ALU32_OVERFLOW_EN adds the ovf_o port and its logic.
module alu32_core
  import alu32_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  alu_fn_t      op_i,
  output logic [N-1:0] res_o,
`ifdef ALU32_OVERFLOW_EN
  output logic         ovf_o,
`endif
  output logic         illegal_o
);

  logic [N-1:0]       sum;
  logic [N-1:0]       dif;
  logic [SHAMT_W-1:0] shamt;
  logic               slt;
  logic               sltu;

  assign sum   = a_i + b_i;
  assign dif   = a_i - b_i;
  assign shamt = a_i[SHAMT_W-1:0];
  assign slt   = $signed(a_i) < $signed(b_i);
  assign sltu  = a_i < b_i;

  always_comb begin
    res_o     = '0;
    illegal_o = 1'b0;
    unique case (op_i)
      FN_ADD,
      FN_ADDU: res_o = sum;
      FN_SUB,
      FN_SUBU: res_o = dif;
      FN_AND:  res_o = a_i & b_i;
      FN_OR:   res_o = a_i | b_i;
      FN_XOR:  res_o = a_i ^ b_i;
      FN_NOR:  res_o = ~(a_i | b_i);
      FN_SLT:  res_o = {{(N-1){1'b0}}, slt};
      FN_SLTU: res_o = {{(N-1){1'b0}}, sltu};
      FN_SLLV: res_o = b_i << shamt;
      FN_SRLV: res_o = b_i >> shamt;
      FN_SRAV: res_o = $signed(b_i) >>> shamt;
      default: illegal_o = 1'b1;
    endcase
  end

`ifdef ALU32_OVERFLOW_EN
  logic add_ovf;
  logic sub_ovf;

  assign add_ovf = (a_i[N-1] == b_i[N-1])
                 & (sum[N-1] != a_i[N-1]);
  assign sub_ovf = (a_i[N-1] != b_i[N-1])
                 & (dif[N-1] != a_i[N-1]);

  // Only the trapping-flavour ops report overflow
  always_comb begin
    ovf_o = 1'b0;
    if (op_i == FN_ADD)
      ovf_o = add_ovf;
    else if (op_i == FN_SUB)
      ovf_o = sub_ovf;
  end
`endif

endmodule

// File: rtl/alu32_bit.sv
// Registered 32-bit MIPS ALU, one-cycle result latency.
// ALU32_OVERFLOW_EN adds the registered overflow output.
module alu32_bit
  import alu32_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [5:0]   opcode,
  output logic [N-1:0] out,
  output logic         out_valid,
  output logic         zero,
`ifdef ALU32_OVERFLOW_EN
  output logic         overflow,
`endif
  output logic         illegal
);

  logic [N-1:0] res;
  logic         ill;

  logic [N-1:0] out_d, out_q;
  logic         vld_d, vld_q;
  logic         ill_d, ill_q;

`ifdef ALU32_OVERFLOW_EN
  logic ovf;
  logic ovf_d, ovf_q;
`endif

  alu32_core #(.N(N)) u_core (
    .a_i       (A),
    .b_i       (B),
    .op_i      (alu_fn_t'(opcode)),
    .res_o     (res),
`ifdef ALU32_OVERFLOW_EN
    .ovf_o     (ovf),
`endif
    .illegal_o (ill)
  );

  // Idle cycles hold the last result; only the valid flag drops
  assign out_d = in_valid ? res : out_q;
  assign ill_d = in_valid ? ill : ill_q;
  assign vld_d = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
      ill_q <= ill_d;
    end
  end

`ifdef ALU32_OVERFLOW_EN
  assign ovf_d = in_valid ? ovf : ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else
      ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

  assign out       = out_q;
  assign out_valid = vld_q;
  assign illegal   = ill_q;
  assign zero      = (out_q == '0);

endmodule

// File: tb/tb_alu32_bit.sv
// Directed self-checking bench for alu32_bit.
// Overflow checks are compiled in only with ALU32_OVERFLOW_EN.
module tb_alu32_bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  opcode;
  logic [31:0] out;
  logic        out_valid;
  logic        zero;
  logic        illegal;
`ifdef ALU32_OVERFLOW_EN
  logic        overflow;
`endif

  int n_chk;
  int n_fail;

  alu32_bit #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out       (out),
    .out_valid (out_valid),
    .zero      (zero),
`ifdef ALU32_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [5:0]  op);
    A        = a;
    B        = b;
    opcode   = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    opcode   = '0;

    #12;
    chk("rst_out", out, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h1);
    chk("rst_vld", {31'b0, out_valid}, 32'h0);
    chk("rst_ill", {31'b0, illegal}, 32'h0);
`ifdef ALU32_OVERFLOW_EN
    chk("rst_ovf", {31'b0, overflow}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back stream, A=10 B=5
    issue(32'd10, 32'd5, 6'b100000);
    chk("add_out", out, 32'd15);
    chk("add_vld", {31'b0, out_valid}, 32'h1);
    chk("add_zero", {31'b0, zero}, 32'h0);
    issue(32'd10, 32'd5, 6'b100100);
    chk("and_out", out, 32'd0);
    chk("and_vld", {31'b0, out_valid}, 32'h1);
    chk("and_zero", {31'b0, zero}, 32'h1);
    issue(32'd10, 32'd5, 6'b100101);
    chk("or_out", out, 32'd15);
    chk("or_zero", {31'b0, zero}, 32'h0);
    issue(32'd10, 32'd5, 6'b101010);
    chk("slt_out", out, 32'd0);
    chk("slt_zero", {31'b0, zero}, 32'h1);
    issue(32'd10, 32'd5, 6'b100010);
    chk("sub_out", out, 32'd5);
    chk("sub_vld", {31'b0, out_valid}, 32'h1);
    chk("sub_zero", {31'b0, zero}, 32'h0);

    // logic ops not covered by the stream
    issue(32'hF0F0_1234, 32'h0FF0_4321, 6'b100110);
    chk("xor_out", out, 32'hFF00_5115);
    issue(32'hF0F0_0000, 32'h0000_000F, 6'b100111);
    chk("nor_out", out, 32'h0F0F_FFF0);
    issue(32'd3, 32'd10, 6'b100011);
    chk("subu_out", out, 32'hFFFF_FFF9);

    // signed vs unsigned compare
    issue(32'hFFFF_FFFF, 32'd1, 6'b101010);
    chk("slt_neg", out, 32'd1);
    issue(32'hFFFF_FFFF, 32'd1, 6'b101011);
    chk("sltu_big", out, 32'd0);

    // shifts
    issue(32'd4, 32'h8000_0000, 6'b000111);
    chk("srav4", out, 32'hF800_0000);
    issue(32'd4, 32'h8000_0000, 6'b000110);
    chk("srlv4", out, 32'h0800_0000);
    issue(32'd0, 32'hA5A5_0001, 6'b000111);
    chk("srav0", out, 32'hA5A5_0001);
    issue(32'd31, 32'h8000_0000, 6'b000111);
    chk("srav31", out, 32'hFFFF_FFFF);
    issue(32'd31, 32'h0000_0001, 6'b000100);
    chk("sllv31", out, 32'h8000_0000);
    issue(32'hFFFF_FFE3, 32'h0000_0001, 6'b000100);
    chk("sllv_amt_lo5", out, 32'h0000_0008);

    // overflow
    issue(32'h7FFF_FFFF, 32'd1, 6'b100000);
    chk("add_ovf_out", out, 32'h8000_0000);
    chk("add_ovf_ill", {31'b0, illegal}, 32'h0);
`ifdef ALU32_OVERFLOW_EN
    chk("add_ovf", {31'b0, overflow}, 32'h1);
`endif
    issue(32'h7FFF_FFFF, 32'd1, 6'b100001);
    chk("addu_out", out, 32'h8000_0000);
`ifdef ALU32_OVERFLOW_EN
    chk("addu_ovf", {31'b0, overflow}, 32'h0);
`endif
    issue(32'h8000_0000, 32'd1, 6'b100010);
    chk("sub_ovf_out", out, 32'h7FFF_FFFF);
`ifdef ALU32_OVERFLOW_EN
    chk("sub_ovf", {31'b0, overflow}, 32'h1);
`endif

    // illegal opcode then recovery
    issue(32'd3, 32'd4, 6'b111111);
    chk("ill_out", out, 32'd0);
    chk("ill_flag", {31'b0, illegal}, 32'h1);
    chk("ill_zero", {31'b0, zero}, 32'h1);
    idle();
    chk("ill_hold", {31'b0, illegal}, 32'h1);
    issue(32'd3, 32'd4, 6'b100000);
    chk("rec_out", out, 32'd7);
    chk("rec_ill", {31'b0, illegal}, 32'h0);

    // hold on idle
    issue(32'd10, 32'd5, 6'b100000);
    chk("hold_pre", out, 32'd15);
    idle();
    chk("hold_out", out, 32'd15);
    chk("hold_vld", {31'b0, out_valid}, 32'h0);

    // asynchronous reset between edges
    issue(32'd10, 32'd5, 6'b100000);
    in_valid = 1'b0;
    chk("pre_rst_vld", {31'b0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", out, 32'h0);
    chk("arst_zero", {31'b0, zero}, 32'h1);
    chk("arst_vld", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd1, 32'd2, 6'b100000);
    chk("post_rst", out, 32'd3);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
